preg_elastic: RTL
=================

Name: preg_elastic

Overview:
- Generic, parametrised pipeline-stage register for the riscv core. It replaces the fixed per-stage registers (IF/DEC, DEC/EX, EX/MEM, MEM/WB).
- Uses a valid/ready elastic handshake instead of global EN/CLR, and carries a control bundle and a data bundle separately.
- Flush inserts a bubble by zeroing the control bundle; data is left untouched.
- A stall-cycle counter supports performance analysis.

Parameters:
- CTRL_W, default 16: width of the control bundle (packed EX/MEM/WB control); zeroed on bubble.
- DATA_W, default 165: width of the data bundle (pc, imm, rs1/rs2 data, register indices, branch info); never zeroed except by reset.
- CNT_W, default 16: width of the stall counter.

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- RSTn, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous flush, for branch mispredict or exception.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: stage can accept a beat.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: downstream beat valid.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: registered control bundle; all-zero whenever out_valid=0.
- out_data, output, DATA_W: registered data bundle.
- occupancy, output, 2: number of beats held (0, 1 or 2).
- stall_cnt, output, CNT_W: count of backpressure cycles.

Behaviour:
- Clock/reset: one clock CLK; reset RSTn is asynchronous, active-low.
- Handshakes:
  - Upstream transfer occurs when in_valid && in_ready.
  - Downstream transfer occurs when out_valid && out_ready.
  - out_valid/out_ctrl/out_data remain stable while out_valid && !out_ready.
- Reset (asynchronous on RSTn falling edge, released synchronously):
  - State = EMPTY.
  - out_valid=0, out_ctrl=0, out_data=0, skid register=0.
  - occupancy=0, stall_cnt=0, in_ready=1.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N; throughput is 1 beat/cycle.
- FSM (skid build):
  - EMPTY: out_valid=0, in_ready=1. Upstream transfer -> FULL (main register loaded).
  - FULL: out_valid=1, in_ready=1.
    - out_ready && in_valid: main register reloaded, stay FULL.
    - out_ready && !in_valid: -> EMPTY.
    - !out_ready && in_valid: beat captured into skid register -> SKID.
    - !out_ready && !in_valid: hold.
  - SKID: out_valid=1, in_ready=0.
    - out_ready: skid moves to main register -> FULL.
    - Otherwise hold.
- in_ready is a registered signal (equal to state != SKID); there is no combinational path from out_ready to in_ready.
- occupancy: EMPTY=0, FULL=1, SKID=2.
- Bubble rule: out_ctrl is forced to zero whenever out_valid=0. out_data keeps its last value (don't-care to consumers).
- Flush (synchronous, highest priority):
  - Next state = EMPTY, out_valid=0, out_ctrl=0, skid contents discarded.
  - Any upstream beat handshaken in the flush cycle is dropped; upstream still sees the transfer as completed.
  - A downstream transfer in the flush cycle completes normally.
  - flush held for several cycles keeps the stage EMPTY.
- stall_cnt:
  - Increments by 1 on every edge where out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset only, not by flush.
- Reset mid-operation: all beats, including skid contents, are lost immediately; outputs take reset values asynchronously.

Optional Feature:
- Macro: PREG_SKID_EN.
- Defined: 2-entry skid buffer as described above; in_ready is registered and occupancy ranges 0..2.
- Undefined:
  - No skid register; FSM has only EMPTY/FULL.
  - in_ready = !out_valid || out_ready, combinational; this is a throughput-1 single register with a combinational ready path.
  - occupancy never exceeds 1.
  - Flush, bubble and counter behaviour are unchanged.

Test Plan:
- Reset: assert RSTn=0 mid-stream with state FULL -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0 without waiting for an edge; in_ready=1 after release.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with in_data=0..7 -> out_data=0..7 one cycle later, no gaps, stall_cnt stays 0.
- Backpressure (skid): FULL with data A, out_ready=0, offer B -> occupancy=2, in_ready=0, out_data=A held. Raise out_ready -> A then B delivered; occupancy 2->1->0.
- Flush: SKID state with in_ctrl=16'hFFFF, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; dropped beat never appears.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds; flush does not clear it.
- Without PREG_SKID_EN: FULL, out_ready=0 -> in_ready=0 in the same cycle. Toggle out_ready=1 -> in_ready=1 combinationally; occupancy never 2.

Source files
------------

// File: rtl/preg_elastic.sv
// preg_elastic: elastic pipeline-stage register, bubble-on-flush, stall counter.
// Define PREG_SKID_EN for the skid build (registered in_ready, occupancy 0..2).
module preg_elastic #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 165,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_main;

`ifdef PREG_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              load_skid;
  logic              from_skid;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: if (in_valid) state_d = S_FULL;
        S_FULL: begin
          if (out_ready && !in_valid)
            state_d = S_EMPTY;
`ifdef PREG_SKID_EN
          else if (!out_ready && in_valid)
            state_d = S_SKID;
`endif
        end
`ifdef PREG_SKID_EN
        S_SKID: if (out_ready) state_d = S_FULL;
`endif
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    occupancy = 2'd0;
    load_main = 1'b0;
`ifdef PREG_SKID_EN
    load_skid = 1'b0;
    from_skid = 1'b0;
`endif
    unique case (state_q)
      S_EMPTY: load_main = in_valid;
      S_FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
        load_main = in_valid && out_ready;
`ifdef PREG_SKID_EN
        load_skid = in_valid && !out_ready;
`else
        // single-register build: ready follows downstream directly
        in_ready  = out_ready;
`endif
      end
`ifdef PREG_SKID_EN
      S_SKID: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        occupancy = 2'd2;
        load_main = out_ready;
        from_skid = out_ready;
      end
`endif
      default: ;
    endcase
  end

`ifdef PREG_SKID_EN
  assign ctrl_d = from_skid ? skid_ctrl_q : in_ctrl;
  assign data_d = from_skid ? skid_data_q : in_data;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      skid_ctrl_q <= '0;
    end else if (load_skid) begin
      skid_ctrl_q <= in_ctrl;
      skid_data_q <= in_data;
    end
  end
`else
  assign ctrl_d = in_ctrl;
  assign data_d = in_data;
`endif

  // flush bubbles the control bundle only; data keeps its last value
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (load_main) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign out_ctrl  = out_valid ? ctrl_q : '0;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

endmodule
